// File: rtl/cond_logic.sv
// Conditional execute logic: gates execute-stage writes on the condition
// result, holds the flag register and squashes wrong-path work after a taken branch.
module cond_logic #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ValidE,
  input  logic       StallE,
  input  logic       CondEx,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagWriteE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       BranchE,
  output logic [3:0] Flags,
  output logic       RegWriteG,
  output logic       MemWriteG,
  output logic       BranchTakenE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       SquashBusy
);

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } state_e;

  localparam logic [2:0] CntInit = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       commit;

  // An instruction retires only when valid, condition-passed, unstalled,
  // outside the squash window and not under reset.
  always_comb begin
    commit = ValidE & CondEx & ~StallE & (state_q == IDLE) & ~rst;
  end

  // Gated execute controls and branch redirect.
  always_comb begin
    RegWriteG    = RegWriteE & commit;
    MemWriteG    = MemWriteE & commit;
    BranchTakenE = BranchE & commit;
    FlushD       = BranchTakenE;
    FlushE       = BranchTakenE;
    SquashBusy   = (state_q == SQUASH);
    Flags        = flags_q;
  end

  // Flag pairs update independently on a committing instruction.
  always_comb begin
    flags_d = flags_q;
    if (commit && FlagWriteE[1]) begin
      flags_d[1:0] = ALUFlags[1:0];
    end
    if (commit && FlagWriteE[0]) begin
      flags_d[3:2] = ALUFlags[3:2];
    end
  end

  // Squash window sequencing; stalls freeze the countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (BranchTakenE) begin
          state_d = SQUASH;
          cnt_d   = CntInit;
        end
      end
      SQUASH: begin
        if (!StallE) begin
          if (cnt_q == 3'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, counter and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: driver pushes expected outputs per cycle,
// monitor pops and compares on the falling edge.
module tb_cond_logic;

  logic       clk;
  logic       rst;
  logic       ValidE;
  logic       StallE;
  logic       CondEx;
  logic [3:0] ALUFlags;
  logic [1:0] FlagWriteE;
  logic       RegWriteE;
  logic       MemWriteE;
  logic       BranchE;
  logic [3:0] Flags;
  logic       RegWriteG;
  logic       MemWriteG;
  logic       BranchTakenE;
  logic       FlushD;
  logic       FlushE;
  logic       SquashBusy;

  typedef struct {
    string      nm;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  cond_logic #(.FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ValidE      (ValidE),
    .StallE      (StallE),
    .CondEx      (CondEx),
    .ALUFlags    (ALUFlags),
    .FlagWriteE  (FlagWriteE),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .BranchE     (BranchE),
    .Flags       (Flags),
    .RegWriteG   (RegWriteG),
    .MemWriteG   (MemWriteG),
    .BranchTakenE(BranchTakenE),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .SquashBusy  (SquashBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are stable mid-cycle, compare against the queued entry.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [9:0] act;
      e   = q.pop_front();
      act = {RegWriteG, MemWriteG, BranchTakenE, FlushD, FlushE,
             SquashBusy, Flags};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got rwg/mwg/bt/fd/fe/sb/flags=%b want %b",
                 e.nm, act, e.v);
      end
    end
  end

  // One cycle of stimulus plus its expected outputs.
  task automatic cyc(
    input string      nm,
    input logic       r,
    input logic       v,
    input logic       s,
    input logic       c,
    input logic [3:0] af,
    input logic [1:0] fw,
    input logic       rw,
    input logic       mw,
    input logic       br,
    input logic       e_rw,
    input logic       e_mw,
    input logic       e_bt,
    input logic       e_sb,
    input logic [3:0] e_fl
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    ValidE     = v;
    StallE     = s;
    CondEx     = c;
    ALUFlags   = af;
    FlagWriteE = fw;
    RegWriteE  = rw;
    MemWriteE  = mw;
    BranchE    = br;
    e.nm = nm;
    e.v  = {e_rw, e_mw, e_bt, e_bt, e_bt, e_sb, e_fl};
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; ValidE = 1'b0; StallE = 1'b0; CondEx = 1'b0;
    ALUFlags = 4'b0; FlagWriteE = 2'b0;
    RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0;
    @(posedge clk);

    //   name          r  v  s  c  af       fw     rw mw br  erw emw ebt esb eflags
    cyc("rst_gate",    1, 1, 0, 1, 4'hF, 2'b11, 1, 1, 1,  0, 0, 0, 0, 4'b0000);
    cyc("rst_idle",    0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 4'b0000);
    cyc("fw_nz",       0, 1, 0, 1, 4'hF, 2'b10, 0, 0, 0,  0, 0, 0, 0, 4'b0000);
    cyc("fw_cv",       0, 1, 0, 1, 4'hC, 2'b01, 0, 0, 0,  0, 0, 0, 0, 4'b0011);
    cyc("fw_all",      0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 4'b1111);
    cyc("cond_fail",   0, 1, 0, 0, 4'h0, 2'b11, 1, 1, 0,  0, 0, 0, 0, 4'b1111);
    cyc("commit_wr",   0, 1, 0, 1, 4'h0, 2'b00, 1, 1, 0,  1, 1, 0, 0, 4'b1111);
    cyc("invalid",     0, 0, 0, 1, 4'h0, 2'b11, 1, 1, 1,  0, 0, 0, 0, 4'b1111);
    cyc("stall_idle",  0, 1, 1, 1, 4'h0, 2'b11, 1, 1, 1,  0, 0, 0, 0, 4'b1111);
    cyc("stall_frz",   0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 4'b1111);
    cyc("br_t",        0, 1, 0, 1, 4'h0, 2'b10, 0, 0, 1,  0, 0, 1, 0, 4'b1111);
    cyc("br_t1",       0, 1, 0, 1, 4'h0, 2'b11, 1, 1, 1,  0, 0, 0, 1, 4'b1100);
    cyc("br_t2",       0, 1, 0, 1, 4'h0, 2'b11, 1, 1, 1,  0, 0, 0, 1, 4'b1100);
    cyc("br_t3",       0, 1, 0, 1, 4'h0, 2'b00, 1, 0, 0,  1, 0, 0, 0, 4'b1100);
    cyc("sbr_t",       0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 1,  0, 0, 1, 0, 4'b1100);
    cyc("sbr_t1",      0, 1, 1, 1, 4'h0, 2'b00, 1, 0, 0,  0, 0, 0, 1, 4'b1100);
    cyc("sbr_t2",      0, 1, 1, 1, 4'h0, 2'b00, 1, 0, 0,  0, 0, 0, 1, 4'b1100);
    cyc("sbr_t3",      0, 1, 1, 1, 4'h0, 2'b00, 1, 0, 0,  0, 0, 0, 1, 4'b1100);
    cyc("sbr_t4",      0, 1, 0, 1, 4'h0, 2'b00, 1, 0, 0,  0, 0, 0, 1, 4'b1100);
    cyc("sbr_t5",      0, 1, 0, 1, 4'h0, 2'b00, 1, 0, 0,  0, 0, 0, 1, 4'b1100);
    cyc("sbr_t6",      0, 1, 0, 1, 4'h0, 2'b01, 1, 0, 0,  1, 0, 0, 0, 4'b1100);
    cyc("sbr_t7",      0, 1, 0, 1, 4'hA, 2'b11, 0, 0, 0,  0, 0, 0, 0, 4'b0000);
    cyc("rbr_t",       0, 1, 0, 1, 4'h0, 2'b00, 0, 0, 1,  0, 0, 1, 0, 4'b1010);
    cyc("rbr_t1_rst",  1, 1, 0, 1, 4'h0, 2'b00, 1, 1, 0,  0, 0, 0, 1, 4'b1010);
    cyc("rbr_t2",      0, 1, 0, 1, 4'h0, 2'b00, 1, 0, 0,  1, 0, 0, 0, 4'b0000);
    cyc("rbr_t3",      0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 4'b0000);

    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d entries left want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning wrong-path squash window after a taken branch; legal range 1..7.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ValidE  input  1  execute-stage instruction valid.
REQ-005 SHALL have port StallE  input  1  execute stage held by hazard unit.
REQ-006 SHALL have port CondEx  input  1  condition result from the condition checker for the current execute instruction.
REQ-007 SHALL have port ALUFlags  input  4  ALU result flags {V,C,Z,N} (bit0=N, bit1=Z, bit2=C, bit3=V).
REQ-008 SHALL have port FlagWriteE  input  2  bit1 = update N,Z; bit0 = update C,V.
REQ-009 SHALL have port RegWriteE, MemWriteE, BranchE  input  1 each  ungated execute controls.
REQ-010 SHALL have port Flags  output  4  architectural flag register, same bit order as ALUFlags, driven to the condition checker.
REQ-011 SHALL have port RegWriteG, MemWriteG  output  1 each  gated write enables.
REQ-012 SHALL have port BranchTakenE  output  1  redirect PC this cycle.
REQ-013 SHALL have port FlushD, FlushE  output  1 each  flush decode/execute pipeline registers.
REQ-014 SHALL have port SquashBusy  output  1  high while in SQUASH state.

Function
REQ-015 SHALL define commit = ValidE & CondEx & ~StallE & (state==IDLE), combinational.
REQ-016 SHALL drive RegWriteG = RegWriteE & commit and MemWriteG = MemWriteE & commit, zero-latency.
REQ-017 SHALL drive BranchTakenE = BranchE & commit, zero-latency.
REQ-018 SHALL drive FlushD = FlushE = BranchTakenE in the same cycle.
REQ-019 SHALL, on a rising edge with commit=1 and FlagWriteE[1]=1, load Flags[1:0] from ALUFlags[1:0].
REQ-020 SHALL, on a rising edge with commit=1 and FlagWriteE[0]=1, load Flags[3:2] from ALUFlags[3:2].
REQ-021 SHALL hold each flag pair unchanged in all other cycles; new flags visible on Flags the cycle after commit.
REQ-022 SHALL implement FSM states IDLE and SQUASH with a 3-bit down-counter cnt.
REQ-023 SHALL transition IDLE->SQUASH when BranchTakenE=1, loading cnt=FLUSH_CYCLES-1.
REQ-024 SHALL, in SQUASH with StallE=0, decrement cnt each cycle and return to IDLE on the edge where cnt==0.
REQ-025 SHALL, in SQUASH with StallE=1, hold cnt and state.
REQ-026 SHALL squash every instruction in execute while in SQUASH: gated outputs 0, no flag update, BranchE ignored.
REQ-027 SHALL, with StallE=1 in IDLE, force all gated outputs to 0 and freeze Flags (no double commit).
REQ-028 SHALL treat CondEx=X or ValidE=0 as no commit (outputs 0).
REQ-029 SHALL assert SquashBusy exactly for the FLUSH_CYCLES unstalled cycles following a taken branch.
REQ-030 SHALL, when a branch also has FlagWriteE!=0, both update flags and enter SQUASH on the same edge.

Reset
REQ-031 SHALL, on rising edge with rst=1, set Flags=4'b0000, state=IDLE, cnt=0, overriding all other updates.
REQ-032 SHALL hold all combinational outputs (RegWriteG, MemWriteG, BranchTakenE, FlushD, FlushE) at 0 while rst=1; SquashBusy=0 after reset edge.
REQ-033 SHALL, on reset mid-SQUASH, return to IDLE with the next instruction committing normally.

Verification
REQ-034 SHALL test flag update: ValidE=1, CondEx=1, FlagWriteE=2'b10, ALUFlags=4'b1111 -> next cycle Flags=4'b0011; then FlagWriteE=2'b01, ALUFlags=4'b1100 -> Flags=4'b1111.
REQ-035 SHALL test condition fail: CondEx=0, RegWriteE=1, MemWriteE=1, FlagWriteE=2'b11 -> RegWriteG=MemWriteG=0, Flags unchanged.
REQ-036 SHALL test branch squash (FLUSH_CYCLES=2): BranchE=1, CondEx=1 at cycle t -> BranchTakenE=FlushD=FlushE=1 at t; SquashBusy=1 at t+1,t+2; RegWriteE=1 at t+1,t+2 gives RegWriteG=0; IDLE at t+3.
REQ-037 SHALL test stall during SQUASH: StallE=1 for 3 cycles at t+1 -> SquashBusy stays 1, IDLE reached at t+6.
REQ-038 SHALL test stall in IDLE: StallE=1, CondEx=1, RegWriteE=1, FlagWriteE=2'b11 -> RegWriteG=0, Flags frozen.
REQ-039 SHALL test reset mid-SQUASH: rst=1 at t+1 -> Flags=0000, SquashBusy=0 at t+2; commit at t+2 gives RegWriteG=1.
